// File: rtl/hazard_forward_scoreboard_pkg.sv
// Shared stage encodings and scoreboard entry layout for the hazard/forwarding unit.
package hazard_pkg;

    localparam logic [1:0] STG_ID  = 2'd0;
    localparam logic [1:0] STG_EX  = 2'd1;
    localparam logic [1:0] STG_MEM = 2'd2;
    localparam logic [1:0] STG_WB  = 2'd3;

    localparam logic [1:0] RDY_ALU  = 2'd1;
    localparam logic [1:0] RDY_LOAD = 2'd2;

    localparam int RW_DEF = 5;
    localparam int SW_DEF = 2;

    // One in-flight producer at the default widths; the top stores the same fields as flat vectors.
    typedef struct packed {
        logic              v;
        logic [RW_DEF-1:0] rd;
        logic              we;
        logic [SW_DEF-1:0] rdy;
    } sb_entry_t;

endpackage

// File: rtl/hazard_forward_scoreboard_if.sv
// ID-stage hazard request bundle and forwarding/stall response.
interface hazard_forward_scoreboard_if #(
    parameter int RW      = 5,
    parameter int NUM_SRC = 2,
    parameter int SW      = 2,
    parameter int CW      = 16
);
    logic                   id_valid;
    logic [RW-1:0]          id_rd;
    logic                   id_reg_write;
    logic [SW-1:0]          id_ready_stage;
    logic [NUM_SRC*RW-1:0]  id_src;
    logic [NUM_SRC-1:0]     id_src_used;
    logic [NUM_SRC*SW-1:0]  id_src_need;
    logic                   flush;
    logic                   stall;
    logic [NUM_SRC*SW-1:0]  fwd_sel;
    logic [NUM_SRC*SW-1:0]  fwd_sel_ex;
    logic [CW-1:0]          stall_cnt;

    modport master (
        output id_valid, id_rd, id_reg_write, id_ready_stage,
               id_src, id_src_used, id_src_need, flush,
        input  stall, fwd_sel, fwd_sel_ex, stall_cnt
    );

    modport slave (
        input  id_valid, id_rd, id_reg_write, id_ready_stage,
               id_src, id_src_used, id_src_need, flush,
        output stall, fwd_sel, fwd_sel_ex, stall_cnt
    );
endinterface

// File: rtl/hazard_forward_scoreboard_forward_match.sv
// Compares one ID source against every scoreboard entry; the youngest matching
// producer decides between a stall and the stage to forward from.
module forward_match
    import hazard_pkg::*;
#(
    parameter int RW     = 5,
    parameter int SW     = 2,
    parameter int STAGES = 3
) (
    input  logic [RW-1:0]        i_src,
    input  logic                 i_used,
    input  logic [SW-1:0]        i_need,
    input  logic [STAGES-1:0]    i_sb_v,
    input  logic [STAGES-1:0]    i_sb_we,
    input  logic [STAGES*RW-1:0] i_sb_rd,
    input  logic [STAGES*SW-1:0] i_sb_rdy,
    output logic                 o_stall,
    output logic [SW-1:0]        o_fwd_sel
);
    // One extra bit so stage + need cannot wrap.
    localparam int DW = SW + 1;

    logic          w_hit;
    logic [DW-1:0] w_stage;
    logic [DW-1:0] w_rdy;
    logic [DW-1:0] w_dist;

    // Scan oldest to youngest so the youngest match is the last one written.
    always_comb begin
        w_hit   = 1'b0;
        w_stage = '0;
        w_rdy   = '0;
        for (int s = STAGES; s >= 1; s--) begin
            if (i_used && (i_src != '0) && i_sb_v[s-1] && i_sb_we[s-1] &&
                (i_sb_rd[(s-1)*RW +: RW] == i_src)) begin
                w_hit   = 1'b1;
                w_stage = DW'(s);
                w_rdy   = {1'b0, i_sb_rdy[(s-1)*SW +: SW]};
            end else begin
                w_hit   = w_hit;
                w_stage = w_stage;
                w_rdy   = w_rdy;
            end
        end
    end

    assign w_dist  = w_stage + {1'b0, i_need};
    assign o_stall = w_hit && (w_dist <= w_rdy);
    // Beyond the last tracked stage the value has reached the regfile (write-through).
    assign o_fwd_sel = (w_hit && !o_stall && (w_dist <= DW'(STAGES))) ? w_dist[SW-1:0] : SW'(STG_ID);

endmodule

// File: rtl/hazard_forward_scoreboard.sv
// Forwarding and stall unit: shift-register scoreboard of in-flight producers
// (entry 1 = EX .. entry STAGES = WB), per-source match, stall counter. Needs STAGES >= 2.
module hazard_forward_scoreboard
    import hazard_pkg::*;
#(
    parameter int RW      = 5,
    parameter int NUM_SRC = 2,
    parameter int STAGES  = 3,
    parameter int SW      = 2,
    parameter int CW      = 16
) (
    input  logic                        i_clk,
    input  logic                        i_reset,
    hazard_forward_scoreboard_if.slave  bus
);
    logic [STAGES-1:0]     r_sb_v;
    logic [STAGES-1:0]     r_sb_we;
    logic [STAGES*RW-1:0]  r_sb_rd;
    logic [STAGES*SW-1:0]  r_sb_rdy;
    logic [NUM_SRC*SW-1:0] r_fwd_sel_ex;
    logic [CW-1:0]         r_stall_cnt;

    logic [NUM_SRC-1:0]    w_src_stall;
    logic [NUM_SRC*SW-1:0] w_fwd_sel;
    logic                  w_stall;
    logic                  w_push;

    for (genvar gi = 0; gi < NUM_SRC; gi++) begin : g_match
        forward_match #(
            .RW     (RW),
            .SW     (SW),
            .STAGES (STAGES)
        ) u_match (
            .i_src     (bus.id_src[gi*RW +: RW]),
            .i_used    (bus.id_src_used[gi]),
            .i_need    (bus.id_src_need[gi*SW +: SW]),
            .i_sb_v    (r_sb_v),
            .i_sb_we   (r_sb_we),
            .i_sb_rd   (r_sb_rd),
            .i_sb_rdy  (r_sb_rdy),
            .o_stall   (w_src_stall[gi]),
            .o_fwd_sel (w_fwd_sel[gi*SW +: SW])
        );
    end

    // A flushed instruction never stalls; it simply becomes a bubble.
    assign w_stall = (|w_src_stall) & bus.id_valid & ~bus.flush;
    assign w_push  = bus.id_valid & ~w_stall & ~bus.flush;

    assign bus.stall      = w_stall;
    assign bus.fwd_sel    = w_fwd_sel;
    assign bus.fwd_sel_ex = r_fwd_sel_ex;
    assign bus.stall_cnt  = r_stall_cnt;

    // Scoreboard advance: downstream never stalls, so every entry moves each cycle.
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_sb_v   <= '0;
            r_sb_we  <= '0;
            r_sb_rd  <= '0;
            r_sb_rdy <= '0;
        end else begin
            r_sb_v   <= {r_sb_v[STAGES-2:0], w_push};
            r_sb_we  <= {r_sb_we[STAGES-2:0], bus.id_reg_write};
            r_sb_rd  <= {r_sb_rd[(STAGES-1)*RW-1:0], bus.id_rd};
            r_sb_rdy <= {r_sb_rdy[(STAGES-1)*SW-1:0], bus.id_ready_stage};
        end
    end

    // Forward selects travel with the instruction into EX.
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_fwd_sel_ex <= '0;
        end else if (w_stall || bus.flush || !bus.id_valid) begin
            r_fwd_sel_ex <= '0;
        end else begin
            r_fwd_sel_ex <= w_fwd_sel;
        end
    end

    // Saturating stall-cycle counter.
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_stall_cnt <= '0;
        end else if (w_stall && (r_stall_cnt != '1)) begin
            r_stall_cnt <= r_stall_cnt + CW'(1);
        end else begin
            r_stall_cnt <= r_stall_cnt;
        end
    end

endmodule

// File: tb/tb_hazard_forward_scoreboard.sv
// Directed table-driven bench for hazard_forward_scoreboard (CW=4 so saturation is reachable).
module tb_hazard_forward_scoreboard;
    import hazard_pkg::*;

    localparam int RW      = 5;
    localparam int NUM_SRC = 2;
    localparam int STAGES  = 3;
    localparam int SW      = 2;
    localparam int CW      = 4;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    hazard_forward_scoreboard_if #(.RW(RW), .NUM_SRC(NUM_SRC), .SW(SW), .CW(CW)) u_if ();

    hazard_forward_scoreboard #(
        .RW(RW), .NUM_SRC(NUM_SRC), .STAGES(STAGES), .SW(SW), .CW(CW)
    ) u_dut (
        .i_clk   (clk),
        .i_reset (reset),
        .bus     (u_if)
    );

    typedef struct {
        logic       rst;
        logic       valid;
        logic [4:0] rd;
        logic       we;
        logic [1:0] rdy;
        logic [4:0] s0;
        logic [4:0] s1;
        logic [1:0] used;
        logic [1:0] n0;
        logic [1:0] n1;
        logic       flush;
        logic       e_stall;
        logic [1:0] e_f0;
        logic [1:0] e_f1;
        logic [1:0] e_x0;
        logic [1:0] e_x1;
        logic [3:0] e_cnt;
    } vec_t;

    int n_checks = 0;
    int n_errors = 0;

    function automatic vec_t mk(input int rst, input int valid, input int rd, input int we,
                                input int rdy, input int s0, input int s1, input int used,
                                input int n0, input int n1, input int flush, input int e_stall,
                                input int e_f0, input int e_f1, input int e_x0, input int e_x1,
                                input int e_cnt);
        vec_t v;
        v.rst = 1'(rst);     v.valid = 1'(valid); v.rd = 5'(rd);   v.we = 1'(we);
        v.rdy = 2'(rdy);     v.s0 = 5'(s0);       v.s1 = 5'(s1);   v.used = 2'(used);
        v.n0 = 2'(n0);       v.n1 = 2'(n1);       v.flush = 1'(flush);
        v.e_stall = 1'(e_stall); v.e_f0 = 2'(e_f0); v.e_f1 = 2'(e_f1);
        v.e_x0 = 2'(e_x0);   v.e_x1 = 2'(e_x1);   v.e_cnt = 4'(e_cnt);
        return v;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    // Drive one ID cycle, check outputs mid-cycle, then advance past the clock edge.
    task automatic apply(input vec_t v, input string tag);
        reset                 = v.rst;
        u_if.id_valid         = v.valid;
        u_if.id_rd            = v.rd;
        u_if.id_reg_write     = v.we;
        u_if.id_ready_stage   = v.rdy;
        u_if.id_src           = {v.s1, v.s0};
        u_if.id_src_used      = v.used;
        u_if.id_src_need      = {v.n1, v.n0};
        u_if.flush            = v.flush;
        #2;
        check({tag, " stall"},   32'(u_if.stall),            32'(v.e_stall));
        check({tag, " fwd0"},    32'(u_if.fwd_sel[1:0]),     32'(v.e_f0));
        check({tag, " fwd1"},    32'(u_if.fwd_sel[3:2]),     32'(v.e_f1));
        check({tag, " fwd_ex0"}, 32'(u_if.fwd_sel_ex[1:0]),  32'(v.e_x0));
        check({tag, " fwd_ex1"}, 32'(u_if.fwd_sel_ex[3:2]),  32'(v.e_x1));
        check({tag, " cnt"},     32'(u_if.stall_cnt),        32'(v.e_cnt));
        @(posedge clk);
        #1;
    endtask

    vec_t tbl [24];
    int   m_cnt;

    initial begin
        // rst valid rd we rdy | s0 s1 used n0 n1 flush | stall f0 f1 x0 x1 cnt
        tbl[0]  = mk(0,1, 8,1,RDY_ALU,   0, 0,0,1,1,0, 0,0,0,0,0,0);
        tbl[1]  = mk(0,1, 0,0,RDY_ALU,   8, 0,1,1,1,0, 0,2,0,0,0,0);
        tbl[2]  = mk(0,0, 0,0,RDY_ALU,   8, 0,0,1,1,0, 0,0,0,2,0,0);
        tbl[3]  = mk(0,1, 9,1,RDY_LOAD,  0, 0,0,1,1,0, 0,0,0,0,0,0);
        tbl[4]  = mk(0,1,11,1,RDY_ALU,   0, 9,2,1,1,0, 1,0,0,0,0,0);
        tbl[5]  = mk(0,1,11,1,RDY_ALU,   0, 9,2,1,1,0, 0,0,3,0,0,1);
        tbl[6]  = mk(0,1,10,1,RDY_ALU,   0, 0,0,1,1,0, 0,0,0,0,3,1);
        tbl[7]  = mk(0,1, 0,0,RDY_ALU,  10, 0,1,0,1,0, 1,0,0,0,0,1);
        tbl[8]  = mk(0,1, 0,0,RDY_ALU,  10, 0,1,0,1,0, 0,2,0,0,0,2);
        tbl[9]  = mk(0,1,10,1,RDY_LOAD,  0, 0,0,1,1,0, 0,0,0,2,0,2);
        tbl[10] = mk(0,1, 0,0,RDY_ALU,  10, 0,1,0,1,0, 1,0,0,0,0,2);
        tbl[11] = mk(0,1, 0,0,RDY_ALU,  10, 0,1,0,1,0, 1,0,0,0,0,3);
        tbl[12] = mk(0,1, 0,0,RDY_ALU,  10, 0,1,0,1,0, 0,3,0,0,0,4);
        tbl[13] = mk(0,1, 5,1,RDY_ALU,   0, 0,0,1,1,0, 0,0,0,3,0,4);
        tbl[14] = mk(0,1, 5,1,RDY_ALU,   0, 0,0,1,1,0, 0,0,0,0,0,4);
        tbl[15] = mk(0,1, 0,0,RDY_ALU,   5, 0,3,1,1,0, 0,2,0,0,0,4);
        tbl[16] = mk(0,1, 0,0,RDY_ALU,   5, 5,0,1,1,0, 0,0,0,2,0,4);
        tbl[17] = mk(0,1, 0,0,RDY_ALU,   0, 5,2,1,1,0, 0,0,0,0,0,4);
        tbl[18] = mk(0,1,12,1,RDY_LOAD,  0, 0,0,1,1,0, 0,0,0,0,0,4);
        tbl[19] = mk(0,1,13,1,RDY_ALU,  12, 0,1,1,1,1, 0,0,0,0,0,4);
        tbl[20] = mk(0,1, 0,0,RDY_ALU,  13,12,3,1,1,0, 0,0,3,0,0,4);
        tbl[21] = mk(0,1,14,1,RDY_LOAD,  0, 0,0,1,1,0, 0,0,0,0,3,4);
        tbl[22] = mk(1,1, 0,0,RDY_ALU,  14, 0,1,1,1,0, 1,0,0,0,0,4);
        tbl[23] = mk(0,1, 0,0,RDY_ALU,  14, 0,1,1,1,0, 0,0,0,0,0,0);

        reset               = 1'b1;
        u_if.id_valid       = 1'b0;
        u_if.id_rd          = 5'd0;
        u_if.id_reg_write   = 1'b0;
        u_if.id_ready_stage = 2'd0;
        u_if.id_src         = 10'd0;
        u_if.id_src_used    = 2'b00;
        u_if.id_src_need    = 4'd0;
        u_if.flush          = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        reset = 1'b0;
        #2;
        check("reset stall",   32'(u_if.stall),      32'd0);
        check("reset fwd",     32'(u_if.fwd_sel),    32'd0);
        check("reset fwd_ex",  32'(u_if.fwd_sel_ex), 32'd0);
        check("reset cnt",     32'(u_if.stall_cnt),  32'd0);
        @(posedge clk);
        #1;

        for (int i = 0; i < 24; i++) begin
            apply(tbl[i], $sformatf("row%0d", i));
        end

        // Load followed by a dependent branch: two stalls per round, drives the counter into saturation.
        m_cnt = 0;
        for (int it = 0; it < 10; it++) begin
            apply(mk(0,1,15,1,RDY_LOAD, 0,0,0,1,1,0, 0,0,0,(it == 0) ? 0 : 3,0,m_cnt),
                  $sformatf("sat%0d ld", it));
            for (int k = 0; k < 2; k++) begin
                apply(mk(0,1,0,0,RDY_ALU, 15,0,1,STG_ID,1,0, 1,0,0,0,0,m_cnt),
                      $sformatf("sat%0d st%0d", it, k));
                m_cnt = (m_cnt < 15) ? m_cnt + 1 : 15;
            end
            apply(mk(0,1,0,0,RDY_ALU, 15,0,1,STG_ID,1,0, 0,3,0,0,0,m_cnt),
                  $sformatf("sat%0d go", it));
        end
        check("sat final cnt", 32'(u_if.stall_cnt), 32'd15);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
